// File: rtl/stopwatch_pkg.sv
// Shared encodings and digit limits for the MM:SS BCD stopwatch.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int BCD_W_DEF    = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } state_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch chain; rolls to 0 on the same edge that
// it reports carry, so the next digit advances in lock-step.
module bcd_digit_cnt #(
  parameter int BCD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = inc & (q == max);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr || carry) begin
      q <= '0;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by a sampled 1 Hz divider output.
// Optional lap-freeze display selected by STOPWATCH_LAP_EN.
//
//   state | meaning
//   IDLE  | stopped at 00:00, waiting for start
//   RUN   | counting on each divider tick
//   PAUSE | digits held, ticks ignored
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int BCD_W        = BCD_W_DEF,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             start_pause,
  input  logic             clear,
  input  logic             lap,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             wrap
);

  localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(DIGIT_MAX);
  localparam logic [BCD_W-1:0] MAX_STEN = BCD_W'(SEC_TENS_MAX);
  localparam logic [BCD_W-1:0] MAX_MTEN = BCD_W'(MIN_TENS_MAX);

  state_t           state;
  logic             clk_div_d;
  logic             tick;
  logic             advance;
  logic             c_so, c_st, c_mo, c_mt;
  logic [BCD_W-1:0] so_q, st_q, mo_q, mt_q;

  // clk_div_d resets high so a divider already high at release is not an edge
  assign tick    = clk_div & ~clk_div_d;
  assign advance = (state == RUN) & tick & ~start_pause & ~clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      running   <= 1'b0;
      wrap      <= 1'b0;
      clk_div_d <= 1'b1;
    end else begin
      clk_div_d <= clk_div;
      wrap      <= c_mt;
      if (clear) begin
        state   <= IDLE;
        running <= 1'b0;
      end else if (start_pause) begin
        case (state)
          IDLE, PAUSE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_digit_cnt #(.BCD_W(BCD_W)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(advance),
    .max(MAX_ONES), .q(so_q), .carry(c_so)
  );

  bcd_digit_cnt #(.BCD_W(BCD_W)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_so),
    .max(MAX_STEN), .q(st_q), .carry(c_st)
  );

  bcd_digit_cnt #(.BCD_W(BCD_W)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_st),
    .max(MAX_ONES), .q(mo_q), .carry(c_mo)
  );

  bcd_digit_cnt #(.BCD_W(BCD_W)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_mo),
    .max(MAX_MTEN), .q(mt_q), .carry(c_mt)
  );

`ifdef STOPWATCH_LAP_EN
  logic             frozen;
  logic [BCD_W-1:0] h_so, h_st, h_mo, h_mt;

  // The live count keeps running underneath; only the display is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frozen <= 1'b0;
      h_so   <= '0;
      h_st   <= '0;
      h_mo   <= '0;
      h_mt   <= '0;
    end else if (clear || (start_pause && state == RUN)) begin
      frozen <= 1'b0;
    end else if (lap) begin
      if (frozen) begin
        frozen <= 1'b0;
      end else if (state == RUN) begin
        frozen <= 1'b1;
        h_so   <= so_q;
        h_st   <= st_q;
        h_mo   <= mo_q;
        h_mt   <= mt_q;
      end
    end
  end

  assign sec_ones = frozen ? h_so : so_q;
  assign sec_tens = frozen ? h_st : st_q;
  assign min_ones = frozen ? h_mo : mo_q;
  assign min_tens = frozen ? h_mt : mt_q;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: vector table plus hand sequences for
// long counts, wrap, pause/clear priority, reset and lap behaviour.
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n, clk_div, start_pause, clear, lap;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic        running, wrap;
  logic [15:0] disp;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          secs  = 0;
  bit          frz   = 1'b0;
  logic [15:0] hold  = 16'h0000;

  typedef struct {
    bit          sp;
    bit          cl;
    bit          div;
    logic [15:0] disp;
    bit          run;
    string       nm;
  } vec_t;

  vec_t tbl[14];

  stopwatch_bcd #(.BCD_W(4), .MIN_TENS_MAX(5)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .start_pause(start_pause),
    .clear(clear), .lap(lap), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .running(running), .wrap(wrap)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int s);
    int m = s / 60;
    int r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [15:0] exp_disp();
    return frz ? hold : to_bcd(secs);
  endfunction

  function automatic vec_t mk(bit sp, bit cl, bit div, logic [15:0] d, bit run, string nm);
    vec_t v;
    v.sp = sp; v.cl = cl; v.div = div; v.disp = d; v.run = run; v.nm = nm;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One divider period: rising edge sampled, then low again.
  task automatic do_tick(input bit adv, input bit chk_disp);
    clk_div = 1'b1;
    step();
    if (adv) secs = (secs + 1) % 3600;
    chk("wrap_at_edge", {15'd0, wrap}, {15'd0, (adv && secs == 0)});
    if (chk_disp) chk("disp_after_tick", disp, exp_disp());
    clk_div = 1'b0;
    step();
    chk("wrap_after", {15'd0, wrap}, 16'd0);
  endtask

  task automatic pulse_sp();
    start_pause = 1'b1;
    step();
    start_pause = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    step();
    lap = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_div = 1'b1; start_pause = 1'b0; clear = 1'b0; lap = 1'b0;

    // Reset with divider high, then release with it still high
    step();
    step();
    chk("rst_disp", disp, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("release_disp", disp, 16'h0000);
      chk("release_running", {15'd0, running}, 16'd0);
    end

    tbl[0]  = mk(1, 0, 0, 16'h0000, 1, "start");
    tbl[1]  = mk(0, 0, 1, 16'h0001, 1, "tick1");
    tbl[2]  = mk(0, 0, 1, 16'h0001, 1, "div_held_high");
    tbl[3]  = mk(0, 0, 0, 16'h0001, 1, "div_low");
    tbl[4]  = mk(0, 0, 1, 16'h0002, 1, "tick2");
    tbl[5]  = mk(1, 0, 0, 16'h0002, 0, "pause");
    tbl[6]  = mk(0, 0, 1, 16'h0002, 0, "tick_in_pause");
    tbl[7]  = mk(1, 0, 0, 16'h0002, 1, "resume");
    tbl[8]  = mk(0, 0, 1, 16'h0003, 1, "tick3");
    tbl[9]  = mk(0, 1, 0, 16'h0000, 0, "clear_in_run");
    tbl[10] = mk(0, 0, 1, 16'h0000, 0, "tick_in_idle");
    tbl[11] = mk(1, 0, 0, 16'h0000, 1, "restart");
    tbl[12] = mk(0, 1, 1, 16'h0000, 0, "clear_with_tick");
    tbl[13] = mk(0, 0, 0, 16'h0000, 0, "idle_settle");

    foreach (tbl[i]) begin
      start_pause = tbl[i].sp;
      clear       = tbl[i].cl;
      clk_div     = tbl[i].div;
      step();
      start_pause = 1'b0;
      clear       = 1'b0;
      chk(tbl[i].nm, disp, tbl[i].disp);
      chk({tbl[i].nm, "_running"}, {15'd0, running}, {15'd0, tbl[i].run});
      chk({tbl[i].nm, "_wrap"}, {15'd0, wrap}, 16'd0);
    end
    secs = 0;

    // 75 divider edges from 00:00
    pulse_sp();
    chk("run_after_start", {15'd0, running}, 16'd1);
    for (int i = 0; i < 75; i++) do_tick(1'b1, 1'b1);
    chk("count_75", disp, 16'h0115);
    chk("count_75_running", {15'd0, running}, 16'd1);

    // Run up to 59:55, then across the wrap
    for (int i = 0; i < 3520; i++) do_tick(1'b1, 1'b0);
    chk("preload_5955", disp, 16'h5955);
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1);
    chk("wrapped_0000", disp, 16'h0000);
    do_tick(1'b1, 1'b1);
    chk("count_after_wrap", disp, 16'h0001);
    chk("running_after_wrap", {15'd0, running}, 16'd1);

    // start_pause coincident with a tick: pause wins, tick dropped
    clk_div = 1'b1;
    start_pause = 1'b1;
    step();
    start_pause = 1'b0;
    chk("sp_tick_disp", disp, 16'h0001);
    chk("sp_tick_running", {15'd0, running}, 16'd0);
    clk_div = 1'b0;
    step();
    for (int i = 0; i < 10; i++) do_tick(1'b0, 1'b1);
    chk("paused_10_ticks", disp, 16'h0001);
    start_pause = 1'b1;
    clear = 1'b1;
    step();
    start_pause = 1'b0;
    clear = 1'b0;
    secs = 0;
    chk("clear_sp_disp", disp, 16'h0000);
    chk("clear_sp_running", {15'd0, running}, 16'd0);

    // Reset mid-count, coincident with a divider edge
    pulse_sp();
    for (int i = 0; i < 42; i++) do_tick(1'b1, 1'b1);
    chk("count_42", disp, 16'h0042);
    rst_n = 1'b0;
    clk_div = 1'b1;
    step();
    chk("midrst_disp", disp, 16'h0000);
    chk("midrst_running", {15'd0, running}, 16'd0);
    chk("midrst_wrap", {15'd0, wrap}, 16'd0);
    rst_n = 1'b1;
    clk_div = 1'b0;
    step();
    secs = 0;
    chk("post_rst_running", {15'd0, running}, 16'd0);

    // Lap freeze (live display when the feature is not built)
    pulse_sp();
    for (int i = 0; i < 10; i++) do_tick(1'b1, 1'b1);
    pulse_lap();
    if (LAP_EN) begin
      frz = 1'b1;
      hold = to_bcd(secs);
    end
    chk("lap_at_10", disp, 16'h0010);
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1);
    chk("lap_held", disp, LAP_EN ? 16'h0010 : 16'h0015);
    pulse_lap();
    frz = 1'b0;
    chk("lap_release", disp, 16'h0015);

    // A pause also releases a held lap
    pulse_lap();
    if (LAP_EN) begin
      frz = 1'b1;
      hold = to_bcd(secs);
    end
    do_tick(1'b1, 1'b1);
    pulse_sp();
    frz = 1'b0;
    chk("pause_releases_lap", disp, 16'h0016);
    chk("pause_running", {15'd0, running}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
